// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer_if
// Description : Bundle of pipeline-side signals exchanged with the interrupt
//               sequencer.
//               slave  : the sequencer's view (pipeline status in, overrides out)
//               master : the pipeline / stack memory view
//   interrupt, rti_dec, hdu_stall, branch_taken, branch_target, pc_fetch,
//   flags_in, stack_rdata               -> into the sequencer
//   freeze, inject_nop, stack_we, stack_re, stack_wdata, pc_load,
//   pc_load_val, flags_load, flags_out, in_isr, busy -> out of the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_sequencer_if #(
  parameter int W    = 16,
  parameter int PC_W = 32
);
  // pipeline status
  logic            interrupt;
  logic            rti_dec;
  logic            hdu_stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc_fetch;
  logic [2:0]      flags_in;
  logic [W-1:0]    stack_rdata;
  // sequencer overrides
  logic            freeze;
  logic            inject_nop;
  logic            stack_we;
  logic            stack_re;
  logic [W-1:0]    stack_wdata;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_val;
  logic            flags_load;
  logic [2:0]      flags_out;
  logic            in_isr;
  logic            busy;

  modport slave (
    input  interrupt, rti_dec, hdu_stall, branch_taken, branch_target,
           pc_fetch, flags_in, stack_rdata,
    output freeze, inject_nop, stack_we, stack_re, stack_wdata, pc_load,
           pc_load_val, flags_load, flags_out, in_isr, busy
  );

  modport master (
    output interrupt, rti_dec, hdu_stall, branch_taken, branch_target,
           pc_fetch, flags_in, stack_rdata,
    input  freeze, inject_nop, stack_we, stack_re, stack_wdata, pc_load,
           pc_load_val, flags_load, flags_out, in_isr, busy
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer
// Description : Sequences the 5-stage pipeline through hardware interrupt
//               entry (drain, push PC high/low and flags, jump to vector) and
//               RTI return (drain, pop flags / PC low / PC high, reload).
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - interrupt_sequencer_if.slave (pipeline status in,
//                      freeze / NOP / stack / PC / flag overrides out)
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
  parameter int              W            = 16,
  parameter int              PC_W         = 32,
  parameter int              DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0] VECTOR       = 32'h0000_0020
) (
  input  wire logic              clk,
  input  wire logic              rst,
  interrupt_sequencer_if.slave   bus
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_ENTER_DRAIN = 4'd1;
  localparam logic [3:0] S_PUSH_PCH    = 4'd2;
  localparam logic [3:0] S_PUSH_PCL    = 4'd3;
  localparam logic [3:0] S_PUSH_FLG    = 4'd4;
  localparam logic [3:0] S_VECTOR      = 4'd5;
  localparam logic [3:0] S_RTI_DRAIN   = 4'd6;
  localparam logic [3:0] S_POP_FLG     = 4'd7;
  localparam logic [3:0] S_POP_PCL     = 4'd8;
  localparam logic [3:0] S_POP_PCH     = 4'd9;
  localparam logic [3:0] S_RESUME      = 4'd10;
  localparam logic [3:0] S_RTI_LOAD    = 4'd11;

  logic [3:0]      state_q,       state_d;
  logic            pending_q,     pending_d;
  logic            in_isr_q,      in_isr_d;
  logic [CNT_W-1:0] drain_cnt_q,  drain_cnt_d;
  logic [PC_W-1:0] ret_pc_q,      ret_pc_d;
  logic [2:0]      saved_flags_q, saved_flags_d;

  logic drain_done;
  logic entry_ok;

  assign drain_done = (drain_cnt_q == DRAIN_LAST);
  // Entry from IDLE is postponed by a load-use stall and masked inside a handler.
  assign entry_ok   = pending_q && !in_isr_q && !bus.hdu_stall;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      in_isr_q      <= 1'b0;
      drain_cnt_q   <= '0;
      ret_pc_q      <= '0;
      saved_flags_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      in_isr_q      <= in_isr_d;
      drain_cnt_q   <= drain_cnt_d;
      ret_pc_q      <= ret_pc_d;
      saved_flags_q <= saved_flags_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and context capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    // A pulse while a request is already latched simply merges into it.
    pending_d     = pending_q | bus.interrupt;
    in_isr_d      = in_isr_q;
    drain_cnt_d   = drain_cnt_q;
    ret_pc_d      = ret_pc_q;
    saved_flags_d = saved_flags_q;

    case (state_q)
      S_IDLE: begin
        // RTI is only honoured inside a handler; entry is masked there, so the
        // two never compete.
        if (bus.rti_dec && in_isr_q) begin
          state_d     = S_RTI_DRAIN;
          drain_cnt_d = '0;
        end else if (entry_ok) begin
          state_d       = S_ENTER_DRAIN;
          drain_cnt_d   = '0;
          pending_d     = 1'b0;
          ret_pc_d      = bus.pc_fetch;
          saved_flags_d = bus.flags_in;
        end
      end

      S_ENTER_DRAIN: begin
        // Instructions still retiring may update the CCR or redirect the PC;
        // the saved context must reflect them.
        saved_flags_d = bus.flags_in;
        if (bus.branch_taken) begin
          ret_pc_d = bus.branch_target;
        end
        if (drain_done) begin
          state_d     = S_PUSH_PCH;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      S_PUSH_PCH: state_d = S_PUSH_PCL;
      S_PUSH_PCL: state_d = S_PUSH_FLG;
      S_PUSH_FLG: state_d = S_VECTOR;

      S_VECTOR: begin
        in_isr_d = 1'b1;
        state_d  = S_IDLE;
      end

      S_RTI_DRAIN: begin
        if (drain_done) begin
          state_d     = S_POP_FLG;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      // Read data lags stack_re by one cycle, so each pop's data is captured
      // in the state that follows it.
      S_POP_FLG: state_d = S_POP_PCL;

      S_POP_PCL: begin
        saved_flags_d = bus.stack_rdata[2:0];
        state_d       = S_POP_PCH;
      end

      S_POP_PCH: begin
        ret_pc_d[W-1:0] = bus.stack_rdata;
        state_d         = S_RESUME;
      end

      S_RESUME: begin
        ret_pc_d[PC_W-1:W] = bus.stack_rdata;
        state_d            = S_RTI_LOAD;
      end

      S_RTI_LOAD: begin
        in_isr_d = 1'b0;
        // A request held during the handler is taken back-to-back. The PC being
        // loaded now is exactly what Fetch will hold next, so ret_pc is already
        // the correct return address; hdu_stall is not consulted outside IDLE.
        if (pending_q) begin
          state_d     = S_ENTER_DRAIN;
          drain_cnt_d = '0;
          pending_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.freeze      = 1'b0;
    bus.inject_nop  = 1'b0;
    bus.stack_we    = 1'b0;
    bus.stack_re    = 1'b0;
    bus.stack_wdata = '0;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = '0;
    bus.flags_load  = 1'b0;
    bus.flags_out   = '0;

    case (state_q)
      S_ENTER_DRAIN, S_RTI_DRAIN: begin
        bus.freeze     = 1'b1;
        bus.inject_nop = 1'b1;
      end

      S_PUSH_PCH: begin
        bus.freeze      = 1'b1;
        bus.stack_we    = 1'b1;
        bus.stack_wdata = ret_pc_q[PC_W-1:W];
      end

      S_PUSH_PCL: begin
        bus.freeze      = 1'b1;
        bus.stack_we    = 1'b1;
        bus.stack_wdata = ret_pc_q[W-1:0];
      end

      S_PUSH_FLG: begin
        bus.freeze      = 1'b1;
        bus.stack_we    = 1'b1;
        bus.stack_wdata = {{(W-3){1'b0}}, saved_flags_q};
      end

      S_VECTOR: begin
        bus.freeze      = 1'b1;
        bus.pc_load     = 1'b1;
        bus.pc_load_val = VECTOR;
      end

      S_POP_FLG, S_POP_PCL, S_POP_PCH: begin
        bus.freeze   = 1'b1;
        bus.stack_re = 1'b1;
      end

      // Fetch stays frozen until the restored PC has been loaded.
      S_RESUME: begin
        bus.freeze = 1'b1;
      end

      S_RTI_LOAD: begin
        bus.freeze      = 1'b1;
        bus.pc_load     = 1'b1;
        bus.pc_load_val = ret_pc_q;
        bus.flags_load  = 1'b1;
        bus.flags_out   = saved_flags_q;
      end

      default: ;
    endcase
  end

  assign bus.in_isr = in_isr_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire
